// File: rtl/note_metadata_streamer.sv
// Per-channel note-time streamer for the game note lanes.
// During the load phase, note words are pushed into one FIFO per channel.
// After the end word arrives and song time passes START_TIME, each lane's
// request returns its next note time, or END_MARK once the lane is exhausted.
// Ports:
//   clk, reset_n         clock, async active-low reset
//   clear                sync clear (song reload), same effect as reset
//   song_time            current song time (ms)
//   write_en/write_word  loader word: [31:29] code, [28:23] channel, [15:0] time
//   metadata_request     per-channel level request for the next note time
//   metadata_available   per-channel 1-cycle pulse: link slice updated
//   metadata_link        channel c at [c*TIME_W +: TIME_W]
//   channel_empty        per-channel FIFO empty (registered)
//   loaded               end word seen; load phase closed
//   overflow             sticky: a note word was dropped
module note_metadata_streamer #(
  parameter int unsigned       N_CH       = 37,
  parameter int unsigned       DEPTH      = 16,
  parameter int unsigned       TIME_W     = 16,
  parameter int unsigned       START_TIME = 5,
  parameter logic [TIME_W-1:0] END_MARK   = 16'hFFFF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic [TIME_W-1:0]        song_time,
  input  logic                     write_en,
  input  logic [31:0]              write_word,
  input  logic [N_CH-1:0]          metadata_request,
  output logic [N_CH-1:0]          metadata_available,
  output logic [N_CH*TIME_W-1:0]   metadata_link,
  output logic [N_CH-1:0]          channel_empty,
  output logic                     loaded,
  output logic                     overflow
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [TIME_W-1:0]                mem [N_CH][DEPTH];
  logic [N_CH-1:0][CNT_W-1:0]       cnt;
  logic [N_CH-1:0][CNT_W-1:0]       cnt_nxt;
  logic [N_CH-1:0][PTR_W-1:0]       rd_ptr;
  logic [N_CH-1:0][PTR_W-1:0]       wr_ptr;
  logic [N_CH-1:0]                  push_sel;
  logic [N_CH-1:0]                  serve;
  logic [N_CH-1:0]                  pop;
  logic                             running;
  logic [2:0]                       code;
  logic [5:0]                       wch;
  logic [TIME_W-1:0]                wtime;
  logic                             note_word;
  logic                             end_word;
  logic                             ch_ok;
  logic                             drop;
  logic [6:0]                       unused_word_bits;

  assign code             = write_word[31:29];
  assign wch              = write_word[28:23];
  assign wtime            = TIME_W'(write_word[15:0]);
  assign unused_word_bits = write_word[22:16];

  // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Word decode, per-channel push/serve/pop and next occupancy.
  always_comb begin
    push_sel  = '0;
    serve     = '0;
    pop       = '0;
    cnt_nxt   = cnt;
    note_word = write_en && !loaded && (code == 3'b000);
    end_word  = write_en && !loaded && (code == 3'b111);
    ch_ok     = 32'(wch) < N_CH;
    for (int c = 0; c < N_CH; c++) begin
      if (note_word && ch_ok && (wch == 6'(c)) && (cnt[c] != CNT_W'(DEPTH)))
        push_sel[c] = 1'b1;
      serve[c] = metadata_request[c] && running && !metadata_available[c];
      pop[c]   = serve[c] && (cnt[c] != '0);
      if (push_sel[c])
        cnt_nxt[c] = cnt[c] + CNT_W'(1);
      else if (pop[c])
        cnt_nxt[c] = cnt[c] - CNT_W'(1);
    end
    // A note word that selected no FIFO was either out of range or hit a full one.
    drop = note_word && (push_sel == '0);
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (push_sel[c])
        mem[c][wr_ptr[c]] <= wtime;
    end
  end

  // Control state, pointers and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt                <= '0;
      rd_ptr             <= '0;
      wr_ptr             <= '0;
      running            <= 1'b0;
      loaded             <= 1'b0;
      overflow           <= 1'b0;
      metadata_available <= '0;
      metadata_link      <= '0;
      channel_empty      <= '1;
    end else if (clear) begin
      cnt                <= '0;
      rd_ptr             <= '0;
      wr_ptr             <= '0;
      running            <= 1'b0;
      loaded             <= 1'b0;
      overflow           <= 1'b0;
      metadata_available <= '0;
      metadata_link      <= '0;
      channel_empty      <= '1;
    end else begin
      if (end_word)
        loaded <= 1'b1;
      if (drop)
        overflow <= 1'b1;
      if (loaded && (song_time > TIME_W'(START_TIME)))
        running <= 1'b1;
      cnt <= cnt_nxt;
      for (int c = 0; c < N_CH; c++) begin
        channel_empty[c]      <= (cnt_nxt[c] == '0);
        metadata_available[c] <= serve[c];
        if (push_sel[c])
          wr_ptr[c] <= ptr_inc(wr_ptr[c]);
        if (pop[c])
          rd_ptr[c] <= ptr_inc(rd_ptr[c]);
        if (serve[c])
          metadata_link[c*TIME_W +: TIME_W] <= pop[c] ? mem[c][rd_ptr[c]] : END_MARK;
      end
    end
  end

endmodule

// File: tb/tb_note_metadata_streamer.sv
// Self-checking bench for note_metadata_streamer: table-driven load vectors,
// a scoreboard queue of expected (channel, time) pulses, and hand sequences
// for latency, simultaneous serve, async reset, clear and post-load writes.
module tb_note_metadata_streamer;
  localparam int unsigned N_CH   = 37;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned TIME_W = 16;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   clear;
  logic [TIME_W-1:0]      song_time;
  logic                   write_en;
  logic [31:0]            write_word;
  logic [N_CH-1:0]        metadata_request;
  logic [N_CH-1:0]        metadata_available;
  logic [N_CH*TIME_W-1:0] metadata_link;
  logic [N_CH-1:0]        channel_empty;
  logic                   loaded;
  logic                   overflow;

  note_metadata_streamer #(
    .N_CH(N_CH), .DEPTH(DEPTH), .TIME_W(TIME_W), .START_TIME(5), .END_MARK(16'hFFFF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .song_time(song_time),
    .write_en(write_en), .write_word(write_word), .metadata_request(metadata_request),
    .metadata_available(metadata_available), .metadata_link(metadata_link),
    .channel_empty(channel_empty), .loaded(loaded), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic        exp_ovf;
    logic        exp_loaded;
    int          ch;
    logic        exp_empty;
  } vec_t;

  typedef struct {
    int          ch;
    logic [15:0] t;
  } exp_t;

  exp_t sb[$];
  int   p24[$];
  int   cyc = 0;
  int   pulses = 0;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] mk(input logic [2:0] code, input int ch, input logic [15:0] t);
    return {code, 6'(ch), 7'd0, t};
  endfunction

  task automatic expect_pulse(input int ch, input logic [15:0] t);
    exp_t e;
    e.ch = ch;
    e.t  = t;
    sb.push_back(e);
  endtask

  // One clock, then sample 1 time unit after the edge and score any pulses.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < N_CH; c++) begin
      if (metadata_available[c]) begin
        pulses++;
        if (c == 24) p24.push_back(cyc);
        if (sb.size() == 0) begin
          check($sformatf("unexpected_pulse_ch%0d", c), 32'(metadata_available[c]), 32'd0);
        end else begin
          e = sb.pop_front();
          check("sb_channel", 32'(c), 32'(e.ch));
          check($sformatf("sb_link_ch%0d", c), 32'(metadata_link[c*TIME_W +: TIME_W]), 32'(e.t));
        end
      end
    end
  endtask

  task automatic wr(input logic [31:0] w);
    write_en   = 1'b1;
    write_word = w;
    tick();
    write_en   = 1'b0;
    write_word = '0;
  endtask

  task automatic serve_once(input int ch);
    bit got;
    got = 1'b0;
    metadata_request[ch] = 1'b1;
    for (int i = 0; i < 6 && !got; i++) begin
      tick();
      got = metadata_available[ch];
    end
    metadata_request[ch] = 1'b0;
    check($sformatf("serve_once_ch%0d_pulse", ch), 32'(got), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t            tbl [9];
    logic [N_CH-1:0] saved;
    int              c0;
    int              pbase;

    tbl[0] = '{mk(3'd0, 24, 16'd400),  1'b0, 1'b0, 24, 1'b0};
    tbl[1] = '{mk(3'd0, 24, 16'd2000), 1'b0, 1'b0, 24, 1'b0};
    tbl[2] = '{mk(3'd0, 24, 16'd3000), 1'b0, 1'b0, 24, 1'b0};
    tbl[3] = '{mk(3'd0, 28, 16'd111),  1'b0, 1'b0, 28, 1'b0};
    tbl[4] = '{mk(3'd0, 28, 16'd222),  1'b0, 1'b0, 28, 1'b0};
    tbl[5] = '{mk(3'd0, 28, 16'd333),  1'b0, 1'b0, 28, 1'b0};
    tbl[6] = '{mk(3'd0, 31, 16'd700),  1'b0, 1'b0, 31, 1'b0};
    tbl[7] = '{mk(3'b010, 30, 16'd999), 1'b0, 1'b0, 30, 1'b1};
    tbl[8] = '{mk(3'd0, 36, 16'd5),    1'b0, 1'b0, 36, 1'b0};

    reset_n = 1'b0; clear = 1'b0; song_time = '0;
    write_en = 1'b0; write_word = '0; metadata_request = '0;
    tick(); tick();
    check("rst_available", 32'(|metadata_available), 32'd0);
    check("rst_link", 32'(|metadata_link), 32'd0);
    check("rst_empty_all", 32'(&channel_empty), 32'd1);
    check("rst_loaded", 32'(loaded), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Load table.
    for (int i = 0; i < 9; i++) begin
      wr(tbl[i].word);
      check($sformatf("tbl%0d_overflow", i), 32'(overflow), 32'(tbl[i].exp_ovf));
      check($sformatf("tbl%0d_loaded", i), 32'(loaded), 32'(tbl[i].exp_loaded));
      check($sformatf("tbl%0d_empty_ch%0d", i, tbl[i].ch), 32'(channel_empty[tbl[i].ch]),
            32'(tbl[i].exp_empty));
    end

    // Fill ch26 to DEPTH, then one more.
    for (int i = 0; i < 16; i++) wr(mk(3'd0, 26, 16'(1000 + i)));
    check("ch26_full_no_overflow", 32'(overflow), 32'd0);
    wr(mk(3'd0, 26, 16'd9999));
    check("ch26_17th_overflow", 32'(overflow), 32'd1);
    saved = channel_empty;
    wr(mk(3'd0, 40, 16'd1));
    check("ch40_overflow_sticky", 32'(overflow), 32'd1);
    check("ch40_empty_unchanged", 32'(channel_empty != saved), 32'd0);
    wr(mk(3'd0, 37, 16'd1));
    check("ch37_empty_unchanged", 32'(channel_empty != saved), 32'd0);

    // Request before end word: nothing served.
    song_time = 16'd6;
    metadata_request[24] = 1'b1;
    pbase = pulses;
    repeat (4) tick();
    check("no_pulse_before_loaded", 32'(pulses - pbase), 32'd0);
    metadata_request[24] = 1'b0;
    song_time = 16'd5;
    wr(mk(3'b111, 0, 16'd0));
    check("end_word_loaded", 32'(loaded), 32'd1);

    // song_time == START_TIME is not enough.
    metadata_request[24] = 1'b1;
    pbase = pulses;
    repeat (4) tick();
    check("no_pulse_at_start_time", 32'(pulses - pbase), 32'd0);

    // Held request on ch24: alternate-cycle pulses, then END_MARK.
    expect_pulse(24, 16'd400);
    expect_pulse(24, 16'd2000);
    expect_pulse(24, 16'd3000);
    expect_pulse(24, 16'hFFFF);
    expect_pulse(24, 16'hFFFF);
    p24.delete();
    song_time = 16'd6;
    c0 = cyc;
    for (int i = 0; i < 20 && p24.size() < 5; i++) begin
      tick();
      if (p24.size() == 5) metadata_request[24] = 1'b0;
    end
    metadata_request[24] = 1'b0;
    check("ch24_pulse_count", 32'(p24.size()), 32'd5);
    if (p24.size() > 0) check("ch24_first_latency", 32'(p24[0] - c0), 32'd2);
    for (int i = 1; i < p24.size(); i++)
      check($sformatf("ch24_gap%0d", i), 32'(p24[i] - p24[i-1]), 32'd2);
    pbase = pulses;
    repeat (3) tick();
    check("ch24_no_pulse_after_release", 32'(pulses - pbase), 32'd0);

    // Four channels in the same cycle.
    expect_pulse(24, 16'hFFFF);
    expect_pulse(26, 16'd1000);
    expect_pulse(28, 16'd111);
    expect_pulse(31, 16'd700);
    metadata_request[24] = 1'b1; metadata_request[26] = 1'b1;
    metadata_request[28] = 1'b1; metadata_request[31] = 1'b1;
    tick();
    check("simultaneous_pulses",
          32'({metadata_available[24], metadata_available[26],
               metadata_available[28], metadata_available[31]}), 32'hF);
    metadata_request = '0;
    pbase = pulses;
    repeat (3) tick();
    check("no_pulse_after_simul", 32'(pulses - pbase), 32'd0);
    check("ch31_empty_after_pop", 32'(channel_empty[31]), 32'd1);

    // Async reset in the middle of a ch28 pulse.
    expect_pulse(28, 16'd222);
    serve_once(28);
    metadata_request[28] = 1'b1;
    check("ch28_pulse_before_reset", 32'(metadata_available[28]), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_available", 32'(|metadata_available), 32'd0);
    check("async_rst_link", 32'(|metadata_link), 32'd0);
    check("async_rst_empty_all", 32'(&channel_empty), 32'd1);
    check("async_rst_loaded", 32'(loaded), 32'd0);
    metadata_request = '0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Clear during load.
    wr(mk(3'd0, 24, 16'd5));
    wr(mk(3'd0, 50, 16'd1));
    check("pre_clear_overflow", 32'(overflow), 32'd1);
    check("pre_clear_ch24_empty", 32'(channel_empty[24]), 32'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_empty_all", 32'(&channel_empty), 32'd1);
    check("clear_loaded", 32'(loaded), 32'd0);
    check("clear_overflow", 32'(overflow), 32'd0);

    // Writes after the end word are ignored.
    wr(mk(3'd0, 30, 16'd77));
    check("ch30_loaded_entry", 32'(channel_empty[30]), 32'd0);
    wr(mk(3'b111, 0, 16'd0));
    check("reload_loaded", 32'(loaded), 32'd1);
    tick(); tick();
    saved = channel_empty;
    wr(mk(3'd0, 30, 16'd88));
    check("post_end_empty_unchanged", 32'(channel_empty != saved), 32'd0);
    wr(mk(3'd0, 50, 16'd1));
    check("post_end_overflow_unchanged", 32'(overflow), 32'd0);
    expect_pulse(30, 16'd77);
    serve_once(30);
    check("ch30_empty_after_pop", 32'(channel_empty[30]), 32'd1);
    expect_pulse(30, 16'hFFFF);
    serve_once(30);

    repeat (3) tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
